host_dw_wr_packer: RTL and testbench

//  Upstream write master feeding the host memory interface's DW write path.

---
 rtl/host_dw_wr_packer.sv | 178 +++++++++++++++++
 tb/tb_host_dw_wr_packer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/host_dw_wr_packer.sv
// Byte-stream to DW write packer: gathers command bytes into aligned DW writes with
// byte enables, then optionally follows them with a single MSI-X write.
module host_dw_wr_packer #(
  parameter int          LEN_W     = 16,
  parameter logic [63:0] MSIX_ADDR = 64'h0000_0000_0000_0001,
  parameter logic [31:0] MSIX_DATA = 32'h1234_5678
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [63:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_irq,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [7:0]       din_byte,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [63:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic [3:0]       wr_be,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_SEND = 3'd2,
    ST_IRQ  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [63:0]      addr_r;
  logic [LEN_W-1:0] rem_r;
  logic             irq_r;
  logic [1:0]       lane_r;
  logic [31:0]      data_r;
  logic [3:0]       be_r;
  logic             din_ready_r;
  logic             wr_valid_r;
  logic [63:0]      wr_addr_r;
  logic [31:0]      wr_data_r;
  logic [3:0]       wr_be_r;
  logic             done_r;

  logic             byte_acc_s;
  logic             last_byte_s;
  logic [31:0]      data_nxt_s;
  logic [3:0]       be_nxt_s;

  assign cmd_ready = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign din_ready = din_ready_r;
  assign wr_valid  = wr_valid_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign wr_be     = wr_be_r;
  assign done      = done_r;

  // Merge the byte being accepted this cycle into the partial DW.
  always_comb begin
    byte_acc_s  = din_valid & din_ready_r;
    data_nxt_s  = data_r;
    be_nxt_s    = be_r;
    last_byte_s = 1'b0;
    if (byte_acc_s) begin
      data_nxt_s[{lane_r, 3'b000} +: 8] = din_byte;
      be_nxt_s[lane_r]                  = 1'b1;
      last_byte_s                       = (lane_r == 2'd3) || (rem_r == LEN_ONE);
    end else begin
      last_byte_s = 1'b0;
    end
  end

  // Control FSM with registered write-port, din_ready and done outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      addr_r      <= 64'h0;
      rem_r       <= LEN_ZERO;
      irq_r       <= 1'b0;
      lane_r      <= 2'd0;
      data_r      <= 32'h0;
      be_r        <= 4'h0;
      din_ready_r <= 1'b0;
      wr_valid_r  <= 1'b0;
      wr_addr_r   <= 64'h0;
      wr_data_r   <= 32'h0;
      wr_be_r     <= 4'h0;
      done_r      <= 1'b0;
    end else begin
      // done trails the DONE state by one cycle so it never precedes the last handshake
      done_r <= (state_r == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_r <= cmd_addr;
            rem_r  <= cmd_len;
            irq_r  <= cmd_irq;
            lane_r <= cmd_addr[1:0];
            data_r <= 32'h0;
            be_r   <= 4'h0;
            if (cmd_len != LEN_ZERO) begin
              state_r     <= ST_FILL;
              din_ready_r <= 1'b1;
            end else if (cmd_irq) begin
              state_r    <= ST_IRQ;
              wr_valid_r <= 1'b1;
              wr_addr_r  <= MSIX_ADDR;
              wr_data_r  <= MSIX_DATA;
              wr_be_r    <= 4'hF;
            end else begin
              state_r <= ST_DONE;
            end
          end
        end
        ST_FILL: begin
          if (byte_acc_s) begin
            data_r <= data_nxt_s;
            be_r   <= be_nxt_s;
            lane_r <= lane_r + 2'd1;
            rem_r  <= rem_r - LEN_ONE;
            if (last_byte_s) begin
              state_r     <= ST_SEND;
              din_ready_r <= 1'b0;
              wr_valid_r  <= 1'b1;
              wr_addr_r   <= {addr_r[63:2], 2'b00};
              wr_data_r   <= data_nxt_s;
              wr_be_r     <= be_nxt_s;
            end
          end
        end
        ST_SEND: begin
          if (wr_ready) begin
            addr_r <= {addr_r[63:2] + 62'd1, 2'b00};
            lane_r <= 2'd0;
            data_r <= 32'h0;
            be_r   <= 4'h0;
            if (rem_r != LEN_ZERO) begin
              state_r     <= ST_FILL;
              wr_valid_r  <= 1'b0;
              din_ready_r <= 1'b1;
            end else if (irq_r) begin
              state_r   <= ST_IRQ;
              wr_addr_r <= MSIX_ADDR;
              wr_data_r <= MSIX_DATA;
              wr_be_r   <= 4'hF;
            end else begin
              state_r    <= ST_DONE;
              wr_valid_r <= 1'b0;
            end
          end
        end
        ST_IRQ: begin
          if (wr_ready) begin
            state_r    <= ST_DONE;
            wr_valid_r <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          din_ready_r <= 1'b0;
          wr_valid_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_dw_wr_packer.sv
// Scoreboard bench: expected DW writes are derived per byte address from each command
// and compared by an independent monitor at every write handshake.
module tb_host_dw_wr_packer;

  localparam int          LEN_W     = 16;
  localparam logic [63:0] MSIX_ADDR = 64'h0000_0000_0000_0001;
  localparam logic [31:0] MSIX_DATA = 32'h1234_5678;

  typedef struct packed {
    logic [63:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [63:0]      cmd_addr = 64'h0;
  logic [LEN_W-1:0] cmd_len = 16'h0;
  logic             cmd_irq = 1'b0;
  logic             din_valid = 1'b0;
  logic             din_ready;
  logic [7:0]       din_byte = 8'h0;
  logic             wr_valid;
  logic             wr_ready = 1'b1;
  logic [63:0]      wr_addr;
  logic [31:0]      wr_data;
  logic [3:0]       wr_be;
  logic             busy;
  logic             done;

  host_dw_wr_packer #(.LEN_W(LEN_W), .MSIX_ADDR(MSIX_ADDR), .MSIX_DATA(MSIX_DATA)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_irq(cmd_irq),
    .din_valid(din_valid), .din_ready(din_ready), .din_byte(din_byte),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int       checks = 0;
  int       failures = 0;
  longint   cyc = 0;
  longint   accept_cyc = 0;
  longint   last_done_cyc = 0;
  wr_t      exp_q[$];
  logic [7:0] byte_q[$];
  int       exp_done = 0;
  bit       force_low = 1'b0;
  bit       rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Byte source: random gaps, pops a byte only after it was handshaken.
  initial begin
    bit acc;
    forever begin
      @(negedge clk);
      acc = din_valid && din_ready && rst_n;
      @(posedge clk);
      #1;
      if (acc && byte_q.size() > 0) void'(byte_q.pop_front());
      if (byte_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        din_valid = 1'b1;
        din_byte  = byte_q[0];
      end else begin
        din_valid = 1'b0;
        din_byte  = 8'($urandom);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    wr_ready = force_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1);
  end

  // Monitor: write handshakes, stall stability, done ordering.
  initial begin
    bit prev_stall = 1'b0;
    wr_t p;
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          chk("stall_hold", 64'({wr_valid, wr_addr[15:0], wr_data, wr_be} ^ {1'b1, p.a[15:0], p.d, p.be}), 64'h0);
        if (prev_stall) chk("stall_hold_addr", wr_addr, p.a);
        if (wr_valid && wr_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_wr", wr_addr, 64'hDEAD_DEAD_DEAD_DEAD);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", wr_addr, e.a);
            chk("wr_data", 64'(wr_data), 64'(e.d));
            chk("wr_be", 64'(wr_be), 64'(e.be));
          end
        end
        if (wr_valid && !wr_ready) chk("stall_din_busy", 64'({din_ready, busy}), 64'(2'b01));
        prev_stall = wr_valid && !wr_ready;
        p.a = wr_addr; p.d = wr_data; p.be = wr_be;
        if (done) begin
          last_done_cyc = cyc;
          if (exp_done == 0) begin
            chk("unexpected_done", 64'(1), 64'(0));
          end else begin
            exp_done--;
            chk("done_after_writes", 64'(exp_q.size()), 64'(0));
          end
        end
      end
    end
  end

  // Reference: walk byte addresses, start a new DW whenever the aligned address changes.
  task automatic issue_cmd(input logic [63:0] addr, input int len, input bit irq, input bit seq);
    logic [63:0] a;
    logic [63:0] cur;
    logic [31:0] d;
    logic [3:0]  be;
    logic [7:0]  b;
    bit          have;
    int          n;
    have = 1'b0; cur = 64'h0; d = 32'h0; be = 4'h0;
    for (int i = 0; i < len; i++) begin
      b = seq ? 8'(i + 1) : 8'($urandom);
      a = addr + 64'(i);
      if (have && {a[63:2], 2'b00} != cur) begin
        exp_q.push_back('{cur, d, be});
        d = 32'h0; be = 4'h0;
      end
      have = 1'b1;
      cur = {a[63:2], 2'b00};
      d[8*int'(a[1:0]) +: 8] = b;
      be[a[1:0]] = 1'b1;
      byte_q.push_back(b);
    end
    if (have) exp_q.push_back('{cur, d, be});
    if (irq) exp_q.push_back('{MSIX_ADDR, MSIX_DATA, 4'hF});
    exp_done++;
    @(posedge clk);
    #1;
    cmd_addr = addr; cmd_len = 16'(len); cmd_irq = irq; cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 1000);
    if (!cmd_ready) chk("cmd_accept_timeout", 64'(0), 64'(1));
    accept_cyc = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr = {$urandom, $urandom}; cmd_len = 16'($urandom); cmd_irq = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_done > 0 || byte_q.size() > 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_complete", 64'(exp_done + byte_q.size()), 64'(0));
    if (exp_done > 0 || byte_q.size() > 0) begin
      exp_q.delete(); byte_q.delete(); exp_done = 0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, 64'({cmd_ready, din_ready, wr_valid, busy, done, wr_be}), 64'(9'b1_0000_0000));
    chk({tag, "_addr"}, wr_addr, 64'h0);
    chk({tag, "_data"}, 64'(wr_data), 64'(0));
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    issue_cmd(64'h1000, 8, 1'b0, 1'b1); wait_idle();
    issue_cmd(64'h2001, 5, 1'b0, 1'b1); wait_idle();
    issue_cmd(64'h3000, 4, 1'b1, 1'b1); wait_idle();
    issue_cmd(64'h4000, 0, 1'b0, 1'b1); wait_idle();
    chk("len0_done_latency", 64'(last_done_cyc - accept_cyc), 64'(2));
    issue_cmd(64'h4000, 0, 1'b1, 1'b1); wait_idle();

    // Long write-port stall in the middle of a command.
    fork
      begin issue_cmd(64'h6002, 11, 1'b1, 1'b0); wait_idle(); end
      begin
        n = 0;
        while (!wr_valid && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #1; force_low = 1'b1;
        repeat (10) @(posedge clk);
        #1; force_low = 1'b0;
      end
    join

    issue_cmd(64'hFFFF_FFFF_FFFF_FFFC, 8, 1'b0, 1'b1); wait_idle();

    // Reset while a DW write is stalled.
    force_low = 1'b1;
    issue_cmd(64'h5000, 8, 1'b1, 1'b0);
    n = 0;
    while (!wr_valid && n < 200) begin @(negedge clk); n++; end
    chk("reached_send", 64'(wr_valid), 64'(1));
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midsend_reset");
    exp_q.delete(); byte_q.delete(); exp_done = 0;
    force_low = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    issue_cmd(64'h7003, 6, 1'b1, 1'b0); wait_idle();

    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [63:0] ra;
      ra = (k % 8 == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15))) : {$urandom, $urandom};
      issue_cmd(ra, $urandom_range(0, 20), 1'($urandom), 1'b0);
      wait_idle();
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
